// File: rtl/cve2_pkg.sv
// Shared CVE2 types: privilege levels, PMP access kinds and
// the data-side PMP gate state encoding.
package cve2_pkg;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_M = 2'b11
    } priv_lvl_e;

    typedef enum logic [1:0] {
        PMP_ACC_EXEC  = 2'b00,
        PMP_ACC_WRITE = 2'b01,
        PMP_ACC_READ  = 2'b10
    } pmp_req_e;

    typedef enum logic [2:0] {
        GATE_IDLE,
        GATE_CHECK,
        GATE_BUS_REQ,
        GATE_BUS_WAIT,
        GATE_FAULT
    } pmp_gate_state_e;

    localparam logic [7:0] FAULT_CNT_MAX = 8'hFF;

endpackage

// File: rtl/cve2_pmp_data_gate.sv
// Data-side PMP gate: holds one LSU request, asks the PMP for a
// verdict, then either faults locally or forwards it to the bus.
module cve2_pmp_data_gate
    import cve2_pkg::*;
#(
    parameter bit PMPEnable = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    output logic        lsu_gnt_o,
    input  logic [31:0] lsu_addr_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_wdata_i,
    input  priv_lvl_e   priv_mode_i,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        lsu_pmp_err_o,
    output logic [31:0] fault_addr_o,
    output logic [7:0]  fault_cnt_o,
    output logic [33:0] pmp_req_addr_o,
    output pmp_req_e    pmp_req_type_o,
    output priv_lvl_e   pmp_priv_mode_o,
    input  logic        pmp_req_err_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i
);

    pmp_gate_state_e state_q, state_d;

    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    priv_lvl_e   priv_q;
    pmp_req_e    type_q;
    logic [31:0] fault_addr_q;
    logic [7:0]  fault_cnt_q;

    logic accept;

    assign accept = (state_q == GATE_IDLE) && lsu_req_i;

    always_comb begin
        state_d       = state_q;
        lsu_gnt_o     = 1'b0;
        data_req_o    = 1'b0;
        lsu_rvalid_o  = 1'b0;
        lsu_rdata_o   = 32'h0;
        lsu_err_o     = 1'b0;
        lsu_pmp_err_o = 1'b0;
        unique case (state_q)
            GATE_IDLE: begin
                lsu_gnt_o = lsu_req_i;
                if (lsu_req_i) begin
                    state_d = PMPEnable ? GATE_CHECK : GATE_BUS_REQ;
                end
            end
            GATE_CHECK: begin
                state_d = (PMPEnable && pmp_req_err_i) ? GATE_FAULT
                                                       : GATE_BUS_REQ;
            end
            GATE_BUS_REQ: begin
                data_req_o = 1'b1;
                if (data_gnt_i) begin
                    state_d = GATE_BUS_WAIT;
                end
            end
            GATE_BUS_WAIT: begin
                if (data_rvalid_i) begin
                    lsu_rvalid_o = 1'b1;
                    lsu_rdata_o  = data_rdata_i;
                    lsu_err_o    = data_err_i;
                    state_d      = GATE_IDLE;
                end
            end
            GATE_FAULT: begin
                lsu_rvalid_o  = 1'b1;
                lsu_pmp_err_o = 1'b1;
                state_d       = GATE_IDLE;
            end
            default: state_d = GATE_IDLE;
        endcase
    end

    // The access type is held as a register (not decoded from we_q) so
    // that every PMP channel output reads zero straight out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= GATE_IDLE;
            addr_q       <= 32'h0;
            we_q         <= 1'b0;
            be_q         <= 4'h0;
            wdata_q      <= 32'h0;
            priv_q       <= PRIV_LVL_U;
            type_q       <= PMP_ACC_EXEC;
            fault_addr_q <= 32'h0;
            fault_cnt_q  <= 8'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= lsu_addr_i;
                we_q    <= lsu_we_i;
                be_q    <= lsu_be_i;
                wdata_q <= lsu_wdata_i;
                priv_q  <= priv_mode_i;
                type_q  <= lsu_we_i ? PMP_ACC_WRITE : PMP_ACC_READ;
            end
            if (state_q == GATE_FAULT) begin
                fault_addr_q <= addr_q;
                if (fault_cnt_q != FAULT_CNT_MAX) begin
                    fault_cnt_q <= fault_cnt_q + 8'd1;
                end
            end
        end
    end

    assign pmp_req_addr_o  = {2'b00, addr_q};
    assign pmp_req_type_o  = type_q;
    assign pmp_priv_mode_o = priv_q;

    assign data_addr_o  = addr_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;

    assign fault_addr_o = fault_addr_q;
    assign fault_cnt_o  = fault_cnt_q;

endmodule

// File: tb/tb_cve2_pmp_data_gate.sv
// Scoreboard bench for cve2_pmp_data_gate: randomized transactions,
// reference model of fault bookkeeping, plus a PMP-bypassed instance.
module tb_cve2_pmp_data_gate;
    import cve2_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req;
    logic        lsu_gnt;
    logic [31:0] lsu_addr;
    logic        lsu_we;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_wdata;
    priv_lvl_e   priv;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        lsu_pmp_err;
    logic [31:0] fault_addr;
    logic [7:0]  fault_cnt;
    logic [33:0] pmp_addr;
    pmp_req_e    pmp_type;
    priv_lvl_e   pmp_priv;
    logic        pmp_deny;
    logic        data_req;
    logic        data_gnt;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;

    logic        np_req;
    logic        np_gnt;
    logic        np_rvalid;
    logic [31:0] np_rdata;
    logic        np_err;
    logic        np_pmp_err;
    logic [31:0] np_fault_addr;
    logic [7:0]  np_fault_cnt;
    logic [33:0] np_pmp_addr;
    pmp_req_e    np_pmp_type;
    priv_lvl_e   np_pmp_priv;
    logic        np_data_req;
    logic        np_data_gnt;
    logic [31:0] np_data_addr;
    logic        np_data_we;
    logic [3:0]  np_data_be;
    logic [31:0] np_data_wdata;
    logic        np_data_rvalid;
    logic [31:0] np_data_rdata;
    logic        np_deny_tied;

    always #5 clk = ~clk;

    cve2_pmp_data_gate #(.PMPEnable(1'b1)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .lsu_req_i(lsu_req), .lsu_gnt_o(lsu_gnt),
        .lsu_addr_i(lsu_addr), .lsu_we_i(lsu_we),
        .lsu_be_i(lsu_be), .lsu_wdata_i(lsu_wdata),
        .priv_mode_i(priv),
        .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
        .lsu_err_o(lsu_err), .lsu_pmp_err_o(lsu_pmp_err),
        .fault_addr_o(fault_addr), .fault_cnt_o(fault_cnt),
        .pmp_req_addr_o(pmp_addr), .pmp_req_type_o(pmp_type),
        .pmp_priv_mode_o(pmp_priv), .pmp_req_err_i(pmp_deny),
        .data_req_o(data_req), .data_gnt_i(data_gnt),
        .data_addr_o(data_addr), .data_we_o(data_we),
        .data_be_o(data_be), .data_wdata_o(data_wdata),
        .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
        .data_err_i(data_err)
    );

    cve2_pmp_data_gate #(.PMPEnable(1'b0)) u_dut_np (
        .clk_i(clk), .rst_i(rst),
        .lsu_req_i(np_req), .lsu_gnt_o(np_gnt),
        .lsu_addr_i(lsu_addr), .lsu_we_i(lsu_we),
        .lsu_be_i(lsu_be), .lsu_wdata_i(lsu_wdata),
        .priv_mode_i(priv),
        .lsu_rvalid_o(np_rvalid), .lsu_rdata_o(np_rdata),
        .lsu_err_o(np_err), .lsu_pmp_err_o(np_pmp_err),
        .fault_addr_o(np_fault_addr), .fault_cnt_o(np_fault_cnt),
        .pmp_req_addr_o(np_pmp_addr), .pmp_req_type_o(np_pmp_type),
        .pmp_priv_mode_o(np_pmp_priv), .pmp_req_err_i(np_deny_tied),
        .data_req_o(np_data_req), .data_gnt_i(np_data_gnt),
        .data_addr_o(np_data_addr), .data_we_o(np_data_we),
        .data_be_o(np_data_be), .data_wdata_o(np_data_wdata),
        .data_rvalid_i(np_data_rvalid), .data_rdata_i(np_data_rdata),
        .data_err_i(1'b0)
    );

    typedef struct {
        logic        pmp;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        got;
    int          checks = 0;
    int          errors = 0;
    int          hs_cnt = 0;
    int          req_seen = 0;
    int          rv_cnt = 0;
    int          m_cnt = 0;
    logic [31:0] m_faddr = 32'h0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every lsu_rvalid pulse.
    always @(negedge clk) begin
        #1;
        if (data_req) req_seen++;
        if (data_req && data_gnt) hs_cnt++;
        if (lsu_rvalid) begin
            rv_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", 64'(lsu_rvalid), 64'd0);
            end else begin
                got = sb.pop_front();
                chk("rsp_pmp_err", 64'(lsu_pmp_err), 64'(got.pmp));
                chk("rsp_rdata", 64'(lsu_rdata), 64'(got.rdata));
                chk("rsp_err", 64'(lsu_err), 64'(got.err));
            end
        end else begin
            chk("flags_idle", {62'd0, lsu_pmp_err, lsu_err}, 64'd0);
        end
    end

    task automatic txn(input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] wd,
                       input priv_lvl_e p, input logic deny,
                       input int gdly, input int rdly,
                       input logic [31:0] rd, input logic e);
        int hs0;
        int rs0;
        hs0 = hs_cnt;
        rs0 = req_seen;
        @(negedge clk);
        lsu_req   = 1'b1;
        lsu_addr  = a;
        lsu_we    = w;
        lsu_be    = b;
        lsu_wdata = wd;
        priv      = p;
        pmp_deny  = deny;
        #1;
        chk("lsu_gnt", 64'(lsu_gnt), 64'd1);
        if (deny) begin
            sb.push_back('{1'b1, 32'h0, 1'b0});
            m_cnt   = (m_cnt == 255) ? 255 : m_cnt + 1;
            m_faddr = a;
        end else begin
            sb.push_back('{1'b0, rd, e});
        end
        @(negedge clk);
        lsu_req   = 1'b0;
        lsu_addr  = $urandom;
        lsu_we    = ~w;
        lsu_wdata = $urandom;
        #1;
        chk("pmp_addr", 64'(pmp_addr), {30'd0, 2'b00, a});
        chk("pmp_type", 64'(pmp_type),
            64'(w ? PMP_ACC_WRITE : PMP_ACC_READ));
        chk("pmp_priv", 64'(pmp_priv), 64'(p));
        chk("req_early", 64'(data_req), 64'd0);
        @(negedge clk);
        #1;
        if (deny) begin
            chk("pmp_fault_t2", 64'(lsu_pmp_err), 64'd1);
            @(negedge clk);
            #1;
            chk("fault_addr", 64'(fault_addr), 64'(m_faddr));
            chk("fault_cnt", 64'(fault_cnt), 64'(m_cnt));
            chk("no_bus_req", 64'(req_seen - rs0), 64'd0);
        end else begin
            chk("req_t2", 64'(data_req), 64'd1);
            for (int i = 0; i < gdly; i++) begin
                @(negedge clk);
                #1;
                chk("req_hold", 64'(data_req), 64'd1);
                chk("bus_addr", 64'(data_addr), 64'(a));
            end
            @(negedge clk);
            data_gnt = 1'b1;
            #1;
            chk("bus_bundle", {data_we, data_be, data_wdata, data_addr},
                {w, b, wd, a});
            @(negedge clk);
            data_gnt = 1'b0;
            for (int i = 0; i < rdly; i++) @(negedge clk);
            data_rvalid = 1'b1;
            data_rdata  = rd;
            data_err    = e;
            @(negedge clk);
            data_rvalid = 1'b0;
            data_rdata  = $urandom;
            data_err    = 1'b0;
            #1;
            chk("handshakes", 64'(hs_cnt - hs0), 64'd1);
        end
        @(negedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic stray_rvalid();
        int rv0;
        rv0 = rv_cnt;
        @(negedge clk);
        data_rvalid = 1'b1;
        data_rdata  = $urandom;
        @(negedge clk);
        data_rvalid = 1'b0;
        #1;
        chk("stray_ignored", 64'(rv_cnt - rv0), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv0;
        logic [31:0] ra;
        rst = 1'b1;
        lsu_req = 1'b0;
        lsu_addr = 32'h0;
        lsu_we = 1'b0;
        lsu_be = 4'h0;
        lsu_wdata = 32'h0;
        priv = PRIV_LVL_M;
        pmp_deny = 1'b0;
        data_gnt = 1'b0;
        data_rvalid = 1'b0;
        data_rdata = 32'h0;
        data_err = 1'b0;
        np_req = 1'b0;
        np_data_gnt = 1'b0;
        np_data_rvalid = 1'b0;
        np_data_rdata = 32'h0;
        np_deny_tied = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outputs",
            {lsu_gnt, lsu_rvalid, lsu_err, lsu_pmp_err, data_req,
             fault_cnt, pmp_type, pmp_priv},
            64'd0);
        chk("rst_pmp_addr", 64'(pmp_addr), 64'd0);
        chk("rst_fault_addr", 64'(fault_addr), 64'd0);
        chk("rst_bus_addr", {data_addr, data_wdata}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        txn(32'h1000, 1'b0, 4'hF, 32'h0, PRIV_LVL_U, 1'b0, 2, 1,
            32'hDEADBEEF, 1'b0);
        txn(32'h2004, 1'b1, 4'h3, 32'h1234_5678, PRIV_LVL_S, 1'b1,
            0, 0, 32'h0, 1'b0);
        txn(32'h3008, 1'b0, 4'h1, 32'h0, PRIV_LVL_M, 1'b0, 0, 0,
            32'hCAFEF00D, 1'b1);
        stray_rvalid();

        for (int i = 0; i < 60; i++) begin
            txn($urandom, 1'($urandom), 4'($urandom), $urandom,
                priv_lvl_e'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom, 1'($urandom));
            if ($urandom_range(0, 4) == 0) stray_rvalid();
        end

        for (int i = 0; i < 300; i++) begin
            txn($urandom, 1'($urandom), 4'hF, $urandom, PRIV_LVL_U,
                1'b1, 0, 0, 32'h0, 1'b0);
        end
        chk("fault_cnt_sat", 64'(fault_cnt), 64'd255);

        rv0 = rv_cnt;
        @(negedge clk);
        lsu_req  = 1'b1;
        lsu_addr = 32'h4000;
        pmp_deny = 1'b0;
        @(negedge clk);
        lsu_req = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_txn_req", 64'(data_req), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 0;
        #1;
        chk("rst_drop_req", 64'(data_req), 64'd0);
        chk("rst_clear_cnt", 64'(fault_cnt), 64'd0);
        chk("rst_clear_faddr", 64'(fault_addr), 64'd0);
        @(negedge clk);
        data_rvalid = 1'b1;
        data_rdata  = 32'hBAD0BAD0;
        @(negedge clk);
        data_rvalid = 1'b0;
        #1;
        chk("rst_late_rvalid", 64'(rv_cnt - rv0), 64'd0);

        txn(32'h5000, 1'b1, 4'hC, 32'hA5A5A5A5, PRIV_LVL_M, 1'b1,
            0, 0, 32'h0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            @(negedge clk);
            np_req   = 1'b1;
            lsu_addr = ra;
            lsu_we   = 1'($urandom);
            #1;
            chk("np_gnt", 64'(np_gnt), 64'd1);
            @(negedge clk);
            np_req = 1'b0;
            #1;
            chk("np_req_t1", 64'(np_data_req), 64'd1);
            chk("np_addr", 64'(np_data_addr), 64'(ra));
            np_data_gnt = 1'b1;
            @(negedge clk);
            np_data_gnt    = 1'b0;
            np_data_rvalid = 1'b1;
            np_data_rdata  = ra ^ 32'hFFFF0000;
            #1;
            chk("np_rvalid", 64'(np_rvalid), 64'd1);
            chk("np_rdata", 64'(np_rdata), 64'(ra ^ 32'hFFFF0000));
            chk("np_no_pmp_err", {np_pmp_err, np_err}, 64'd0);
            @(negedge clk);
            np_data_rvalid = 1'b0;
            #1;
            chk("np_fault_cnt", 64'(np_fault_cnt), 64'd0);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/cve2_pmp_data_gate.md
CVE2_PMP_DATA_GATE -- requirements
Module: cve2_pmp_data_gate

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk_i.
REQ-002 The block SHALL have parameter PMPEnable, default 1, meaning: 1 = PMP check stage present, 0 = check bypassed.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- lsu_req_i  in  1  LSU request
- lsu_gnt_o  out  1  request accepted
- lsu_addr_i  in  32  byte address
- lsu_we_i  in  1  1 = write
- lsu_be_i  in  4  byte enables
- lsu_wdata_i  in  32  write data
- priv_mode_i  in  priv_lvl_e  effective privilege
- lsu_rvalid_o  out  1  response valid
- lsu_rdata_o  out  32  read data
- lsu_err_o  out  1  bus error
- lsu_pmp_err_o  out  1  PMP fault
- fault_addr_o  out  32  address of last PMP fault (mtval)
- fault_cnt_o  out  8  saturating PMP fault count
- pmp_req_addr_o  out  34  PMP check address
- pmp_req_type_o  out  pmp_req_e  PMP access type
- pmp_priv_mode_o  out  priv_lvl_e  PMP channel privilege
- pmp_req_err_i  in  1  PMP verdict, 1 = deny
- data_req_o, data_gnt_i, data_addr_o[32], data_we_o, data_be_o[4], data_wdata_o[32]  bus request, OBI semantics
- data_rvalid_i, data_rdata_i[32], data_err_i  bus response

Function
REQ-004 States SHALL be IDLE, CHECK, BUS_REQ, BUS_WAIT and FAULT.
REQ-005 lsu_gnt_o SHALL be asserted combinationally only in IDLE; when lsu_req_i is high in IDLE, addr, we, be, wdata and priv SHALL be captured into holding registers.
REQ-006 On acceptance, the next state SHALL be CHECK if PMPEnable=1, else BUS_REQ.
REQ-007 pmp_req_addr_o SHALL be {2'b00, held addr}; pmp_req_type_o SHALL be PMP_ACC_WRITE if held we is set, else PMP_ACC_READ; pmp_priv_mode_o SHALL be the held priv; all three SHALL be driven from the holding registers only.
REQ-008 In CHECK, pmp_req_err_i SHALL be sampled once: 1 -> FAULT, 0 -> BUS_REQ.
REQ-009 In BUS_REQ, data_req_o SHALL be 1 and data_addr_o/we/be/wdata SHALL equal the held values and stay stable until data_gnt_i; on data_gnt_i the next state SHALL be BUS_WAIT.
REQ-010 In BUS_WAIT, on data_rvalid_i the block SHALL pulse lsu_rvalid_o for 1 cycle, pass lsu_rdata_o = data_rdata_i and lsu_err_o = data_err_i, and return to IDLE.
REQ-011 In FAULT, the block SHALL pulse lsu_rvalid_o with lsu_pmp_err_o = 1, lsu_rdata_o = 0 and lsu_err_o = 0, load fault_addr_o with the held addr, increment fault_cnt_o saturating at 255, and return to IDLE; no bus request SHALL be issued.
REQ-012 data_rvalid_i outside BUS_WAIT SHALL be ignored.
REQ-013 lsu_rvalid_o, lsu_pmp_err_o and lsu_err_o SHALL be 0 in all states other than those in REQ-010/REQ-011.
REQ-014 Minimum latency SHALL be: accept at cycle T, PMP fault response at T+2; bus request at T+2 (PMPEnable=1) or T+1 (PMPEnable=0).
REQ-015 With PMPEnable=0, pmp_req_err_i SHALL be ignored and fault_cnt_o SHALL remain 0.

Reset
REQ-016 rst_i SHALL force IDLE and clear holding registers, fault_addr_o and fault_cnt_o; all outputs SHALL be 0 after reset.
REQ-017 Reset mid-transaction SHALL drop data_req_o in the cycle after reset is sampled; any late rvalid SHALL be ignored per REQ-012.

Structure
REQ-018 priv_lvl_e and pmp_req_e SHALL come from cve2_pkg; the state enum pmp_gate_state_e SHALL be added to cve2_pkg.
REQ-019 No sub-module SHALL be instantiated; cve2_pmp SHALL be instantiated by the parent and connected to the pmp_* ports.

Verification
REQ-020 Read at addr 0x1000 with pmp_req_err_i=0, gnt after 2 cycles and rvalid with rdata 0xDEADBEEF -> exactly one data_req handshake, lsu_rvalid_o=1 with lsu_rdata_o=0xDEADBEEF, lsu_err_o=0.
REQ-021 Write at addr 0x2004 with pmp_req_err_i=1 -> data_req_o never asserted, lsu_pmp_err_o=1 at T+2, fault_addr_o=0x2004, fault_cnt_o=1, pmp_req_type_o=PMP_ACC_WRITE in CHECK.
REQ-022 Issue 300 consecutive denied requests -> fault_cnt_o saturates at 255.
REQ-023 Assert rst_i while in BUS_REQ, then pulse data_rvalid_i -> data_req_o=0 after reset, no lsu_rvalid_o pulse.
REQ-024 With PMPEnable=0 and pmp_req_err_i tied 1 -> data_req_o at T+1, no PMP fault reported.
REQ-025 Data response with data_err_i=1 -> lsu_err_o=1, lsu_pmp_err_o=0.
